// File: rtl/fft_stage_writeback.sv
// fft_stage_writeback: buffers butterfly pairs and serialises them into a ping-pong stage RAM.
// Define FFT_WB_BITREV_EN to bit-reverse write addresses for natural-order output.
module fft_stage_writeback #(
  parameter int bit_width = 29,
  parameter int N         = 256,
  parameter int SIZE      = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [SIZE-1:0]             adr_ptr1,
  input  logic [SIZE-1:0]             adr_ptr2,
  input  logic signed [bit_width-1:0] data1_re,
  input  logic signed [bit_width-1:0] data1_im,
  input  logic signed [bit_width-1:0] data2_re,
  input  logic signed [bit_width-1:0] data2_im,
  output logic                        wr_en,
  output logic                        wr_bank,
  output logic [SIZE-1:0]             wr_ptr,
  output logic signed [bit_width-1:0] wr_re,
  output logic signed [bit_width-1:0] wr_im,
  output logic                        frame_ready,
  output logic                        ready_bank,
  input  logic                        rd_release,
  output logic [1:0]                  busy
);

  typedef enum logic [1:0] {IDLE, EMIT1, EMIT2, STALL} state_t;

  localparam int              DEPTH = 4;
  localparam logic [SIZE-1:0] LAST  = SIZE'(N - 1);

  logic [SIZE-1:0]             a1_m [DEPTH];
  logic [SIZE-1:0]             a2_m [DEPTH];
  logic signed [bit_width-1:0] r1_m [DEPTH];
  logic signed [bit_width-1:0] i1_m [DEPTH];
  logic signed [bit_width-1:0] r2_m [DEPTH];
  logic signed [bit_width-1:0] i2_m [DEPTH];

  state_t                      state_q;
  logic [1:0]                  wptr_q;
  logic [1:0]                  rptr_q;
  logic [2:0]                  cnt_q;
  logic [2:0]                  cnt_d;
  logic                        in_ready_q;
  logic                        wr_en_q;
  logic                        wr_bank_q;
  logic                        wr_bank_d;
  logic [SIZE-1:0]             wr_ptr_q;
  logic signed [bit_width-1:0] wr_re_q;
  logic signed [bit_width-1:0] wr_im_q;
  logic                        frame_ready_q;
  logic                        ready_bank_q;
  logic                        rd_bank_q;
  logic [1:0]                  busy_q;
  logic [1:0]                  busy_d;
  logic [SIZE-1:0]             wcnt_q;

  logic                        push;
  logic                        pop;
  logic                        from_mem;
  logic                        avail;
  logic                        last;
  logic                        bank_free;
  logic [1:0]                  hidx;
  logic [SIZE-1:0]             h_a1;
  logic [SIZE-1:0]             h_a2;
  logic signed [bit_width-1:0] h_r1;
  logic signed [bit_width-1:0] h_i1;
  logic signed [bit_width-1:0] h_r2;
  logic signed [bit_width-1:0] h_i2;

  function automatic logic [SIZE-1:0] map_adr(input logic [SIZE-1:0] a);
    logic [SIZE-1:0] r;
`ifdef FFT_WB_BITREV_EN
    for (int i = 0; i < SIZE; i++) r[i] = a[SIZE-1-i];
`else
    r = a;
`endif
    return r;
  endfunction

  // In EMIT2 the head is being popped, so the next pair sits one slot
  // further on; an empty FIFO forwards the incoming pair directly.
  always_comb begin
    push      = in_valid && in_ready_q;
    pop       = (state_q == EMIT2);
    hidx      = rptr_q + {1'b0, pop};
    from_mem  = cnt_q > {2'b00, pop};
    avail     = from_mem || push;
    h_a1      = from_mem ? a1_m[hidx] : adr_ptr1;
    h_a2      = from_mem ? a2_m[hidx] : adr_ptr2;
    h_r1      = from_mem ? r1_m[hidx] : data1_re;
    h_i1      = from_mem ? i1_m[hidx] : data1_im;
    h_r2      = from_mem ? r2_m[hidx] : data2_re;
    h_i2      = from_mem ? i2_m[hidx] : data2_im;
    last      = wr_en_q && (wcnt_q == LAST);
    wr_bank_d = wr_bank_q ^ last;
    bank_free = !busy_q[wr_bank_d];
    cnt_d     = cnt_q + {2'b00, push} - {2'b00, pop};
    busy_d    = busy_q;
    if (rd_release && (busy_q != 2'b00)) busy_d[rd_bank_q] = 1'b0;
    if (last) busy_d[wr_bank_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      a1_m[wptr_q] <= adr_ptr1;
      a2_m[wptr_q] <= adr_ptr2;
      r1_m[wptr_q] <= data1_re;
      i1_m[wptr_q] <= data1_im;
      r2_m[wptr_q] <= data2_re;
      i2_m[wptr_q] <= data2_im;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      wptr_q        <= '0;
      rptr_q        <= '0;
      cnt_q         <= '0;
      in_ready_q    <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_bank_q     <= 1'b0;
      wr_ptr_q      <= '0;
      wr_re_q       <= '0;
      wr_im_q       <= '0;
      frame_ready_q <= 1'b0;
      ready_bank_q  <= 1'b0;
      rd_bank_q     <= 1'b0;
      busy_q        <= 2'b00;
      wcnt_q        <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 2'd1;
      if (pop) rptr_q <= rptr_q + 2'd1;
      cnt_q         <= cnt_d;
      in_ready_q    <= (cnt_d != 3'd4);
      if (wr_en_q) wcnt_q <= wcnt_q + SIZE'(1);
      wr_bank_q     <= wr_bank_d;
      busy_q        <= busy_d;
      frame_ready_q <= last;
      if (last) ready_bank_q <= wr_bank_q;
      if (rd_release && (busy_q != 2'b00)) rd_bank_q <= ~rd_bank_q;
      unique case (state_q)
        EMIT1: begin
          state_q  <= EMIT2;
          wr_en_q  <= 1'b1;
          wr_ptr_q <= map_adr(h_a2);
          wr_re_q  <= h_r2;
          wr_im_q  <= h_i2;
        end
        default: begin
          if (avail && bank_free) begin
            state_q  <= EMIT1;
            wr_en_q  <= 1'b1;
            wr_ptr_q <= map_adr(h_a1);
            wr_re_q  <= h_r1;
            wr_im_q  <= h_i1;
          end else begin
            state_q <= avail ? STALL : IDLE;
            wr_en_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign wr_en       = wr_en_q;
  assign wr_bank     = wr_bank_q;
  assign wr_ptr      = wr_ptr_q;
  assign wr_re       = wr_re_q;
  assign wr_im       = wr_im_q;
  assign frame_ready = frame_ready_q;
  assign ready_bank  = ready_bank_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_fft_stage_writeback.sv
// tb_fft_stage_writeback: directed bench for the FFT stage write-back controller.
// Covers latency, frame completion, stall/release and reset discard.
module tb_fft_stage_writeback;

  localparam int BW = 29;
  localparam int NP = 256;
  localparam int SZ = 8;

`ifdef FFT_WB_BITREV_EN
  localparam logic [SZ-1:0] BR1 = 8'd128;
  localparam logic [SZ-1:0] BR2 = 8'd96;
`else
  localparam logic [SZ-1:0] BR1 = 8'd1;
  localparam logic [SZ-1:0] BR2 = 8'd6;
`endif

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [SZ-1:0]        adr_ptr1 = '0;
  logic [SZ-1:0]        adr_ptr2 = '0;
  logic signed [BW-1:0] data1_re = '0;
  logic signed [BW-1:0] data1_im = '0;
  logic signed [BW-1:0] data2_re = '0;
  logic signed [BW-1:0] data2_im = '0;
  logic                 wr_en;
  logic                 wr_bank;
  logic [SZ-1:0]        wr_ptr;
  logic signed [BW-1:0] wr_re;
  logic signed [BW-1:0] wr_im;
  logic                 frame_ready;
  logic                 ready_bank;
  logic                 rd_release = 1'b0;
  logic [1:0]           busy;

  fft_stage_writeback #(
    .bit_width(BW),
    .N(NP),
    .SIZE(SZ)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .adr_ptr1(adr_ptr1),
    .adr_ptr2(adr_ptr2),
    .data1_re(data1_re),
    .data1_im(data1_im),
    .data2_re(data2_re),
    .data2_im(data2_im),
    .wr_en(wr_en),
    .wr_bank(wr_bank),
    .wr_ptr(wr_ptr),
    .wr_re(wr_re),
    .wr_im(wr_im),
    .frame_ready(frame_ready),
    .ready_bank(ready_bank),
    .rd_release(rd_release),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int                   vecs = 0;
  int                   errs = 0;
  int                   nwr0 = 0;
  int                   nwr1 = 0;
  int                   nfr  = 0;
  int                   nw;
  logic [SZ-1:0]        eptr [$];
  logic signed [BW-1:0] ere  [$];
  logic signed [BW-1:0] eim  [$];

  function automatic logic [SZ-1:0] map(input logic [SZ-1:0] a);
    logic [SZ-1:0] r;
`ifdef FFT_WB_BITREV_EN
    for (int i = 0; i < SZ; i++) r[i] = a[SZ-1-i];
`else
    r = a;
`endif
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vecs++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (frame_ready) nfr++;
    if (wr_en) begin
      if (wr_bank) nwr1++;
      else nwr0++;
      chk("wr_bank_busy", busy[wr_bank], 0);
      chk("wr_pending", eptr.size() != 0, 1);
      if (eptr.size() != 0) begin
        chk("wr_ptr", wr_ptr, eptr.pop_front());
        chk("wr_re", wr_re, ere.pop_front());
        chk("wr_im", wr_im, eim.pop_front());
      end
    end
  endtask

  task automatic send(input logic [SZ-1:0] a1, input logic [SZ-1:0] a2,
                      input int r1, input int i1,
                      input int r2, input int i2);
    int g;
    g = 0;
    adr_ptr1 = a1;
    adr_ptr2 = a2;
    data1_re = BW'(r1);
    data1_im = BW'(i1);
    data2_re = BW'(r2);
    data2_im = BW'(i2);
    in_valid = 1'b1;
    while (!in_ready && g < 600) begin
      step();
      g++;
    end
    chk("send_accept", in_ready, 1);
    if (in_ready) begin
      eptr.push_back(map(a1));
      ere.push_back(BW'(r1));
      eim.push_back(BW'(i1));
      eptr.push_back(map(a2));
      ere.push_back(BW'(r2));
      eim.push_back(BW'(i2));
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic pairs(input int n, input int seed);
    for (int k = 0; k < n; k++)
      send(SZ'(2 * k), SZ'(2 * k + 1), seed + k, -k, seed - k, k + 7);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (eptr.size() != 0 && g < 1000) begin
      step();
      g++;
    end
    chk("drain_left", eptr.size(), 0);
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    in_valid   = 1'b0;
    rd_release = 1'b0;
    step();
    step();
    eptr.delete();
    ere.delete();
    eim.delete();
    nwr0 = 0;
    nwr1 = 0;
    nfr  = 0;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_bank", wr_bank, 0);
    chk("rst_wr_ptr", wr_ptr, 0);
    chk("rst_wr_re", wr_re, 0);
    chk("rst_wr_im", wr_im, 0);
    chk("rst_frame_ready", frame_ready, 0);
    chk("rst_ready_bank", ready_bank, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    step();
    chk("post_rst_in_ready", in_ready, 1);
  endtask

  initial begin
    do_reset();

    send(8'd3, 8'd131, 5, 1, -7, 2);
    chk("p1_wr_en", wr_en, 1);
    chk("p1_ptr", wr_ptr, map(8'd3));
    chk("p1_re", wr_re, BW'(5));
    step();
    chk("p2_wr_en", wr_en, 1);
    chk("p2_ptr", wr_ptr, map(8'd131));
    chk("p2_re", wr_re, BW'(-7));
    step();
    chk("p3_wr_en", wr_en, 0);
    chk("p3_busy", busy, 2'b00);

    do_reset();
    send(8'd1, 8'd6, 11, 12, 13, 14);
    chk("br_ptr1", wr_ptr, BR1);
    step();
    chk("br_ptr2", wr_ptr, BR2);
    step();

    do_reset();
    pairs(128, 100);
    drain();
    step();
    chk("f0_frame_ready", frame_ready, 1);
    chk("f0_ready_bank", ready_bank, 0);
    chk("f0_busy", busy, 2'b01);
    chk("f0_wr_bank", wr_bank, 1);
    chk("f0_writes_b0", nwr0, 256);
    chk("f0_writes_b1", nwr1, 0);
    step();
    chk("f0_pulse_len", frame_ready, 0);

    pairs(128, 300);
    drain();
    step();
    chk("f1_frame_ready", frame_ready, 1);
    chk("f1_ready_bank", ready_bank, 1);
    chk("f1_busy", busy, 2'b11);
    chk("f1_wr_bank", wr_bank, 0);
    chk("f1_writes_b1", nwr1, 256);

    nw = nwr0 + nwr1;
    send(8'd10, 8'd20, 1, 2, 3, 4);
    step();
    step();
    chk("stall_wr_en", wr_en, 0);
    send(8'd11, 8'd21, 5, 6, 7, 8);
    send(8'd12, 8'd22, 9, 10, 11, 12);
    send(8'd13, 8'd23, 13, 14, 15, 16);
    chk("stall_in_ready", in_ready, 0);
    chk("stall_no_write", nwr0 + nwr1, nw);
    chk("stall_busy", busy, 2'b11);
    rd_release = 1'b1;
    step();
    rd_release = 1'b0;
    chk("rel_busy", busy, 2'b10);
    chk("rel_wr_en_t1", wr_en, 0);
    step();
    chk("rel_wr_en_t2", wr_en, 1);
    chk("rel_wr_bank", wr_bank, 0);
    drain();

    do_reset();
    pairs(128, 500);
    drain();
    step();
    chk("sim_busy0", busy, 2'b01);
    pairs(127, 700);
    drain();
    send(8'd254, 8'd255, 9, -9, 19, -19);
    step();
    chk("sim_busy_pre", busy, 2'b01);
    rd_release = 1'b1;
    step();
    rd_release = 1'b0;
    chk("sim_busy_post", busy, 2'b10);
    chk("sim_frame_ready", frame_ready, 1);
    chk("sim_ready_bank", ready_bank, 1);
    chk("sim_wr_bank", wr_bank, 0);

    pairs(60, 900);
    do_reset();
    pairs(128, 1100);
    drain();
    step();
    chk("mr_frame_ready", frame_ready, 1);
    chk("mr_ready_bank", ready_bank, 0);
    chk("mr_busy", busy, 2'b01);
    step();
    chk("mr_frames", nfr, 1);
    chk("mr_writes_b0", nwr0, 256);
    chk("mr_writes_b1", nwr1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
